// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared state encoding, BCD limits and helpers for the time-of-day counter
package time_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_CHECK = 1'b1;

   typedef enum logic {
      IDLE  = ST_IDLE,
      CHECK = ST_CHECK
   } state_t;

   localparam logic [7:0] BCD_MAX_SEC = 8'h59;
   localparam logic [7:0] BCD_MAX_MIN = 8'h59;

   function automatic logic [7:0] to_bcd(input int unsigned n);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(n / 10);
      ones = 4'(n % 10);
      return {tens, ones};
   endfunction

   // Both nibbles must be decimal digits before a plain magnitude compare is meaningful.
   function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
   endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// rtl/bcd_wrap_counter.sv - one packed-BCD time field that wraps from MAX to 00
module bcd_wrap_counter
   import time_pkg::*;
#(
   parameter logic [7:0] MAX = BCD_MAX_SEC
) (
   input  logic       CLK_IN,
   input  logic       nRST,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] value,
   output logic       wrap
);

   logic [7:0] next_val;

   always_comb begin
      wrap = inc && (value == MAX);
      if (value == MAX)
         next_val = 8'h00;
      else if (value[3:0] == 4'd9)
         next_val = {value[7:4] + 4'd1, 4'd0};
      else
         next_val = {value[7:4], value[3:0] + 4'd1};
   end

   always_ff @(posedge CLK_IN) begin
      if (!nRST)
         value <= 8'h00;
      else if (load)
         value <= load_val;
      else if (inc)
         value <= next_val;
   end

endmodule

// File: rtl/time_counter.sv
// rtl/time_counter.sv - BCD hh:mm:ss counter driven by divider ticks, with handshaked time-set load
module time_counter
   import time_pkg::*;
#(
   parameter int H_MAX = 23
) (
   input  logic       CLK_IN,
   input  logic       nRST,
   input  logic       TICK_IN,
   input  logic       RUN,
   input  logic       SET_VALID,
   output logic       SET_READY,
   input  logic [7:0] SET_H,
   input  logic [7:0] SET_M,
   input  logic [7:0] SET_S,
   output logic [7:0] HOUR,
   output logic [7:0] MIN,
   output logic [7:0] SEC,
   output logic       MIN_PULSE,
   output logic       HOUR_PULSE,
   output logic       DAY_PULSE,
   output logic       SET_ERR
);

   localparam logic [7:0] H_MAX_BCD = to_bcd(H_MAX);

   state_t     state;
   logic       tick_d;
   logic       pending;
   logic [7:0] stg_h, stg_m, stg_s;
   logic       tick_rise;
   logic       stage_ok;
   logic       count_inc;
   logic       do_load;
   logic       sec_wrap, min_wrap, hour_wrap;

   assign tick_rise = TICK_IN & ~tick_d & RUN;

   always_comb begin
      stage_ok  = bcd_ok(stg_s, BCD_MAX_SEC) && bcd_ok(stg_m, BCD_MAX_MIN) && bcd_ok(stg_h, H_MAX_BCD);
      count_inc = (state == IDLE) && !SET_VALID && (tick_rise || pending);
      do_load   = (state == CHECK) && stage_ok;
   end

   bcd_wrap_counter #(.MAX(BCD_MAX_SEC)) u_sec (
      .CLK_IN(CLK_IN), .nRST(nRST), .inc(count_inc), .load(do_load),
      .load_val(stg_s), .value(SEC), .wrap(sec_wrap)
   );

   bcd_wrap_counter #(.MAX(BCD_MAX_MIN)) u_min (
      .CLK_IN(CLK_IN), .nRST(nRST), .inc(sec_wrap), .load(do_load),
      .load_val(stg_m), .value(MIN), .wrap(min_wrap)
   );

   bcd_wrap_counter #(.MAX(H_MAX_BCD)) u_hour (
      .CLK_IN(CLK_IN), .nRST(nRST), .inc(min_wrap), .load(do_load),
      .load_val(stg_h), .value(HOUR), .wrap(hour_wrap)
   );

   // tick_d resets high because the divider output is high out of its own reset.
   always_ff @(posedge CLK_IN) begin
      if (!nRST) begin
         state      <= IDLE;
         SET_READY  <= 1'b1;
         pending    <= 1'b0;
         tick_d     <= 1'b1;
         SET_ERR    <= 1'b0;
         MIN_PULSE  <= 1'b0;
         HOUR_PULSE <= 1'b0;
         DAY_PULSE  <= 1'b0;
         stg_h      <= 8'h00;
         stg_m      <= 8'h00;
         stg_s      <= 8'h00;
      end else begin
         tick_d     <= TICK_IN;
         SET_ERR    <= 1'b0;
         MIN_PULSE  <= sec_wrap;
         HOUR_PULSE <= min_wrap;
         DAY_PULSE  <= hour_wrap;
         case (state)
            IDLE: begin
               if (SET_VALID) begin
                  stg_h     <= SET_H;
                  stg_m     <= SET_M;
                  stg_s     <= SET_S;
                  state     <= CHECK;
                  SET_READY <= 1'b0;
                  pending   <= pending | tick_rise;
               end else begin
                  pending   <= pending & tick_rise;
               end
            end
            CHECK: begin
               state     <= IDLE;
               SET_READY <= 1'b1;
               if (stage_ok) begin
                  pending <= 1'b0;
               end else begin
                  SET_ERR <= 1'b1;
                  pending <= pending | tick_rise;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_time_counter.sv
// tb/tb_time_counter.sv - self-checking bench for time_counter in 24 h and 12 h (H_MAX=11) builds
module tb_time_counter;

   logic       CLK_IN = 1'b0;
   logic       nRST = 1'b0;
   logic       TICK_IN = 1'b1;
   logic       RUN = 1'b1;
   logic       SET_VALID = 1'b0;
   logic [7:0] SET_H = 8'h00, SET_M = 8'h00, SET_S = 8'h00;

   logic       SET_READY_A, MIN_PULSE_A, HOUR_PULSE_A, DAY_PULSE_A, SET_ERR_A;
   logic [7:0] HOUR_A, MIN_A, SEC_A;
   logic       SET_READY_B, MIN_PULSE_B, HOUR_PULSE_B, DAY_PULSE_B, SET_ERR_B;
   logic [7:0] HOUR_B, MIN_B, SEC_B;

   int n_checks = 0;
   int n_pass = 0;

   always #5 CLK_IN = ~CLK_IN;

   time_counter #(.H_MAX(23)) dut_a (
      .CLK_IN(CLK_IN), .nRST(nRST), .TICK_IN(TICK_IN), .RUN(RUN),
      .SET_VALID(SET_VALID), .SET_READY(SET_READY_A),
      .SET_H(SET_H), .SET_M(SET_M), .SET_S(SET_S),
      .HOUR(HOUR_A), .MIN(MIN_A), .SEC(SEC_A),
      .MIN_PULSE(MIN_PULSE_A), .HOUR_PULSE(HOUR_PULSE_A), .DAY_PULSE(DAY_PULSE_A),
      .SET_ERR(SET_ERR_A)
   );

   time_counter #(.H_MAX(11)) dut_b (
      .CLK_IN(CLK_IN), .nRST(nRST), .TICK_IN(TICK_IN), .RUN(RUN),
      .SET_VALID(SET_VALID), .SET_READY(SET_READY_B),
      .SET_H(SET_H), .SET_M(SET_M), .SET_S(SET_S),
      .HOUR(HOUR_B), .MIN(MIN_B), .SEC(SEC_B),
      .MIN_PULSE(MIN_PULSE_B), .HOUR_PULSE(HOUR_PULSE_B), .DAY_PULSE(DAY_PULSE_B),
      .SET_ERR(SET_ERR_B)
   );

   // {HOUR, MIN, SEC, MIN_PULSE, HOUR_PULSE, DAY_PULSE, SET_READY, SET_ERR}
   logic [28:0] obs [2];
   assign obs[0] = {HOUR_A, MIN_A, SEC_A, MIN_PULSE_A, HOUR_PULSE_A, DAY_PULSE_A, SET_READY_A, SET_ERR_A};
   assign obs[1] = {HOUR_B, MIN_B, SEC_B, MIN_PULSE_B, HOUR_PULSE_B, DAY_PULSE_B, SET_READY_B, SET_ERR_B};

   function automatic int hmax_of(input int i);
      return (i == 0) ? 23 : 11;
   endfunction

   function automatic logic [7:0] bcd8(input int v);
      logic [3:0] t, u;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   function automatic int dec(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic bit load_ok(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input int hmax);
      if (h[7:4] > 9 || h[3:0] > 9 || m[7:4] > 9 || m[3:0] > 9 || s[7:4] > 9 || s[3:0] > 9)
         return 1'b0;
      return (dec(h) <= hmax) && (dec(m) < 60) && (dec(s) < 60);
   endfunction

   // Reference model: time as seconds since midnight, a busy flag for the one-cycle check
   // and a count of owed seconds (0 or 1).
   int          m_t [2] = '{0, 0};
   bit          m_busy [2] = '{0, 0};
   bit          m_owed [2] = '{0, 0};
   bit          m_err [2] = '{0, 0};
   bit          m_mp [2] = '{0, 0};
   bit          m_hp [2] = '{0, 0};
   bit          m_dp [2] = '{0, 0};
   logic [7:0]  m_h [2], m_m [2], m_s [2];
   bit          m_prev_tick = 1'b1;
   logic [28:0] m_exp [2];

   always @(posedge CLK_IN) begin : model
      bit rise;
      bit bump;
      rise = TICK_IN && !m_prev_tick && RUN;
      m_prev_tick = nRST ? TICK_IN : 1'b1;
      for (int i = 0; i < 2; i++) begin
         bump = 1'b0;
         m_err[i] = 1'b0;
         if (!nRST) begin
            m_t[i] = 0; m_busy[i] = 0; m_owed[i] = 0;
         end else if (!m_busy[i]) begin
            if (SET_VALID) begin
               m_busy[i] = 1'b1;
               m_h[i] = SET_H; m_m[i] = SET_M; m_s[i] = SET_S;
               m_owed[i] = m_owed[i] || rise;
            end else begin
               bump = rise || m_owed[i];
               m_owed[i] = m_owed[i] && rise;
            end
         end else begin
            m_busy[i] = 1'b0;
            if (load_ok(m_h[i], m_m[i], m_s[i], hmax_of(i))) begin
               m_t[i] = dec(m_h[i]) * 3600 + dec(m_m[i]) * 60 + dec(m_s[i]);
               m_owed[i] = 1'b0;
            end else begin
               m_err[i] = 1'b1;
               m_owed[i] = m_owed[i] || rise;
            end
         end
         if (bump) m_t[i] = (m_t[i] + 1) % ((hmax_of(i) + 1) * 3600);
         m_mp[i] = bump && (m_t[i] % 60 == 0);
         m_hp[i] = bump && (m_t[i] % 3600 == 0);
         m_dp[i] = bump && (m_t[i] == 0);
         m_exp[i] = {bcd8(m_t[i] / 3600), bcd8((m_t[i] / 60) % 60), bcd8(m_t[i] % 60),
                     m_mp[i], m_hp[i], m_dp[i], !m_busy[i], m_err[i]};
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(negedge CLK_IN);
   endtask

   task automatic tick();
      TICK_IN = 1'b0; step();
      TICK_IN = 1'b1; step();
   endtask

   task automatic drive_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      SET_VALID = 1'b1; SET_H = h; SET_M = m; SET_S = s; step();
      SET_VALID = 1'b0; step();
   endtask

   task automatic test_reset();
      nRST = 1'b0; TICK_IN = 1'b1; RUN = 1'b1; SET_VALID = 1'b0; step(2);
      nRST = 1'b1; step(3);
      n_checks++;
      if (obs[0] !== {24'h000000, 5'b00010}) $display("FAIL reset_state: got %h expected %h", obs[0], {24'h000000, 5'b00010});
      else n_pass++;
      TICK_IN = 1'b0; step();
      n_checks++;
      if (SEC_A !== 8'h00) $display("FAIL fall_no_count: got SEC=%h expected 00", SEC_A);
      else n_pass++;
      TICK_IN = 1'b1; step();
      n_checks++;
      if (SEC_A !== 8'h01) $display("FAIL first_tick: got SEC=%h expected 01", SEC_A);
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (obs[i] !== m_exp[i]) $display("FAIL reset_model[%0d]: got %h expected %h", i, obs[i], m_exp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_rollover();
      drive_load(8'h23, 8'h59, 8'h58);
      n_checks++;
      if (obs[0] !== {24'h235958, 5'b00010}) $display("FAIL load_235958: got %h expected %h", obs[0], {24'h235958, 5'b00010});
      else n_pass++;
      n_checks++;
      if (SET_ERR_B !== 1'b1) $display("FAIL load_23_on_h11: got SET_ERR=%b expected 1", SET_ERR_B);
      else n_pass++;
      tick();
      n_checks++;
      if (SEC_A !== 8'h59) $display("FAIL sec_59: got %h expected 59", SEC_A);
      else n_pass++;
      tick();
      n_checks++;
      if (obs[0] !== {24'h000000, 5'b11110}) $display("FAIL day_wrap: got %h expected %h", obs[0], {24'h000000, 5'b11110});
      else n_pass++;
      step();
      n_checks++;
      if ({MIN_PULSE_A, HOUR_PULSE_A, DAY_PULSE_A} !== 3'b000) $display("FAIL pulse_width: got %b expected 000", {MIN_PULSE_A, HOUR_PULSE_A, DAY_PULSE_A});
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (obs[i] !== m_exp[i]) $display("FAIL rollover_model[%0d]: got %h expected %h", i, obs[i], m_exp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_bad_loads();
      logic [23:0] saved;
      saved = obs[0][28:5];
      for (int k = 0; k < 2; k++) begin
         SET_VALID = 1'b1; SET_H = 8'h10;
         SET_M = (k == 0) ? 8'h60 : 8'h00;
         SET_S = (k == 0) ? 8'h00 : 8'h1A;
         step();
         n_checks++;
         if (SET_READY_A !== 1'b0) $display("FAIL bad%0d_ready_low: got %b expected 0", k, SET_READY_A);
         else n_pass++;
         SET_VALID = 1'b0; step();
         n_checks++;
         if ({SET_READY_A, SET_ERR_A, obs[0][28:5]} !== {2'b11, saved})
            $display("FAIL bad%0d_reject: got %h expected %h", k, {SET_READY_A, SET_ERR_A, obs[0][28:5]}, {2'b11, saved});
         else n_pass++;
         step();
         n_checks++;
         if (SET_ERR_A !== 1'b0) $display("FAIL bad%0d_err_width: got %b expected 0", k, SET_ERR_A);
         else n_pass++;
      end
   endtask

   task automatic test_tick_load_collision();
      TICK_IN = 1'b0; step();
      TICK_IN = 1'b1; SET_VALID = 1'b1; SET_H = 8'h12; SET_M = 8'h00; SET_S = 8'h00; step();
      SET_VALID = 1'b0; step(2);
      n_checks++;
      if (obs[0][28:5] !== 24'h120000) $display("FAIL collide_valid: got %h expected 120000", obs[0][28:5]);
      else n_pass++;
      n_checks++;
      if (obs[1] !== m_exp[1]) $display("FAIL collide_valid_h11: got %h expected %h", obs[1], m_exp[1]);
      else n_pass++;
      TICK_IN = 1'b0; step();
      TICK_IN = 1'b1; SET_VALID = 1'b1; SET_M = 8'h60; step();
      SET_VALID = 1'b0; step();
      n_checks++;
      if ({SET_ERR_A, obs[0][28:5]} !== {1'b1, 24'h120000}) $display("FAIL collide_invalid_hold: got %h expected %h", {SET_ERR_A, obs[0][28:5]}, {1'b1, 24'h120000});
      else n_pass++;
      step();
      n_checks++;
      if (obs[0][28:5] !== 24'h120001) $display("FAIL collide_invalid_pending: got %h expected 120001", obs[0][28:5]);
      else n_pass++;
   endtask

   task automatic test_run_gate();
      RUN = 1'b0;
      repeat (5) tick();
      n_checks++;
      if (obs[0][28:5] !== 24'h120001) $display("FAIL run_off: got %h expected 120001", obs[0][28:5]);
      else n_pass++;
      RUN = 1'b1; step(3);
      n_checks++;
      if (obs[0][28:5] !== 24'h120001) $display("FAIL run_resume_burst: got %h expected 120001", obs[0][28:5]);
      else n_pass++;
      tick();
      n_checks++;
      if (obs[0][28:5] !== 24'h120002) $display("FAIL run_resume_count: got %h expected 120002", obs[0][28:5]);
      else n_pass++;
   endtask

   task automatic test_h11();
      drive_load(8'h11, 8'h59, 8'h59);
      tick();
      n_checks++;
      if (obs[1] !== {24'h000000, 5'b11110}) $display("FAIL h11_day_wrap: got %h expected %h", obs[1], {24'h000000, 5'b11110});
      else n_pass++;
      n_checks++;
      if (obs[0] !== {24'h120000, 5'b11010}) $display("FAIL h23_noon: got %h expected %h", obs[0], {24'h120000, 5'b11010});
      else n_pass++;
      SET_VALID = 1'b1; SET_H = 8'h05; SET_M = 8'h06; SET_S = 8'h07; step();
      n_checks++;
      if ({SET_READY_A, SET_READY_B} !== 2'b00) $display("FAIL check_ready: got %b expected 00", {SET_READY_A, SET_READY_B});
      else n_pass++;
      nRST = 1'b0; SET_VALID = 1'b0; step();
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (obs[i] !== {24'h000000, 5'b00010}) $display("FAIL reset_in_check[%0d]: got %h expected %h", i, obs[i], {24'h000000, 5'b00010});
         else n_pass++;
      end
      nRST = 1'b1; step();
      n_checks++;
      if (obs[0] !== {24'h000000, 5'b00010}) $display("FAIL after_reset: got %h expected %h", obs[0], {24'h000000, 5'b00010});
      else n_pass++;
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs[i] !== m_exp[i]) $display("FAIL random[%0d] cycle %0d: got %h expected %h", i, c, obs[i], m_exp[i]);
            else n_pass++;
         end
         if ($urandom_range(0, 2) == 0) TICK_IN = ~TICK_IN;
         RUN       = ($urandom_range(0, 9) != 0);
         nRST      = ($urandom_range(0, 799) != 0);
         SET_VALID = ($urandom_range(0, 14) == 0);
         if ($urandom_range(0, 1) == 0) begin
            SET_H = bcd8($urandom_range(0, 23));
            SET_M = ($urandom_range(0, 1) == 0) ? 8'h59 : bcd8($urandom_range(0, 59));
            SET_S = bcd8($urandom_range(50, 59));
         end else begin
            SET_H = 8'($urandom); SET_M = 8'($urandom); SET_S = 8'($urandom);
         end
         step();
      end
      nRST = 1'b1; SET_VALID = 1'b0; step();
   endtask

   initial begin
      test_reset();
      test_rollover();
      test_bad_loads();
      test_tick_load_collision();
      test_run_gate();
      test_h11();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
